// File: rtl/pc_ctrl_seq.sv
// Control sequencer for the accumulator processor.
// Walks fetch/decode/execute, handshakes with instruction memory and
// emits PC control codes (0=hold 1=load 2=+1 3=+m) plus the IR/ACC strobes.
// All outputs are combinational from the registered state, the opcode
// register and the current inputs, so the PC samples pcc on the same edge
// that advances the sequencer.
module pc_ctrl_seq #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       mem_rdy,
  input  logic       acc_zero,
  input  logic       acc_neg,
  output logic       mem_rd,
  output logic       ir_ld,
  output logic [1:0] pcc,
  output logic [1:0] alu_op,
  output logic       acc_ld,
  output logic       halted,
  output logic       err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_HALT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_OPFETCH = 3'd4
  } state_t;

  localparam logic [1:0] PCC_HOLD = 2'd0;
  localparam logic [1:0] PCC_LOAD = 2'd1;
  localparam logic [1:0] PCC_INC  = 2'd2;
  localparam logic [1:0] PCC_SKIP = 2'd3;

  // Last wait cycle before a memory timeout fault.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [2:0]    op, op_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          err_nxt;

  // Sequencer state, opcode, wait counter and sticky fault; clr aborts at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_HALT;
      op    <= 3'd0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state and output decode. The wait counter defaults to zero, so it is
  // cleared on any entry into FETCH/OPFETCH and only counts while stalled there.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = '0;
    err_nxt   = err;
    mem_rd    = 1'b0;
    ir_ld     = 1'b0;
    pcc       = PCC_HOLD;
    alu_op    = 2'd3;
    acc_ld    = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_nxt = S_FETCH;
          err_nxt   = 1'b0;
        end
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_ld     = 1'b1;
          pcc       = PCC_INC;
          op_nxt    = instr[7:5];
          state_nxt = S_DECODE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          3'b110:  state_nxt = S_OPFETCH;
          3'b111:  state_nxt = S_HALT;
          default: state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op)
          3'b001, 3'b010, 3'b011: begin
            acc_ld = 1'b1;
            alu_op = op[1:0] - 2'd1;
          end
          3'b100:  pcc = acc_zero ? PCC_SKIP : PCC_HOLD;
          3'b101:  pcc = acc_neg  ? PCC_SKIP : PCC_HOLD;
          default: ;
        endcase
      end
      S_OPFETCH: begin
        // JMP target is on the data bus; PC loads it directly.
        mem_rd = 1'b1;
        if (mem_rdy) begin
          pcc       = PCC_LOAD;
          state_nxt = S_FETCH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_ctrl_seq.sv
// Self-checking bench for pc_ctrl_seq: directed scenarios followed by a
// random instruction stream, each cycle compared against per-instruction
// expectations built from the sequencer's behavioural rules.
module tb_pc_ctrl_seq;

  logic       clk = 1'b0;
  logic       clr, run, mem_rdy, acc_zero, acc_neg;
  logic [7:0] instr;
  logic       mem_rd, ir_ld, acc_ld, halted, err;
  logic [1:0] pcc, alu_op;
  logic [2:0] state_dbg;

  int   total = 0;
  int   bad   = 0;
  logic exp_err;

  pc_ctrl_seq #(.TIMEOUT(15), .TW(4)) dut (
    .clk(clk), .clr(clr), .run(run), .instr(instr), .mem_rdy(mem_rdy),
    .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_rd(mem_rd), .ir_ld(ir_ld),
    .pcc(pcc), .alu_op(alu_op), .acc_ld(acc_ld), .halted(halted),
    .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {mem_rd, ir_ld, pcc, alu_op, acc_ld, halted, err, state_dbg};

  function automatic logic [11:0] pk(input logic mrd, input logic ild,
                                     input logic [1:0] pc, input logic [1:0] alu,
                                     input logic ald, input logic hlt,
                                     input logic er, input logic [2:0] st);
    return {mrd, ild, pc, alu, ald, hlt, er, st};
  endfunction

  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed={mrd,ild,pcc,alu,ald,hlt,err,st}=%03h expected=%03h", tag, o, e);
    end
  endtask

  // Sit in HALT for n idle cycles, then request run; leaves the DUT entering FETCH.
  task automatic halt_run(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0; mem_rdy = 1'($urandom); instr = 8'($urandom);
      #1 chk("halt_idle", obs, pk(0, 0, 0, 3, 0, 1, exp_err, 0));
      @(negedge clk);
    end
    run = 1'b1;
    #1 chk("halt_run", obs, pk(0, 0, 0, 3, 0, 1, exp_err, 0));
    @(negedge clk);
    run = 1'b0;
    exp_err = 1'b0;
  endtask

  // Memory read in FETCH (st=1) or OPFETCH (st=4) with `waits` stalls before data.
  task automatic mem_phase(input logic [2:0] st, input logic [7:0] b, input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_rdy = 1'b0; instr = 8'($urandom); run = 1'($urandom);
      #1 chk(st == 1 ? "fetch_wait" : "opf_wait", obs, pk(1, 0, 0, 3, 0, 0, exp_err, st));
      @(negedge clk);
    end
    mem_rdy = 1'b1; instr = b; run = 1'($urandom);
    if (st == 1) begin
      #1 chk("fetch_ack", obs, pk(1, 1, 2, 3, 0, 0, exp_err, 1));
    end else begin
      #1 chk("opf_ack", obs, pk(1, 0, 1, 3, 0, 0, exp_err, 4));
    end
    @(negedge clk);
  endtask

  // Memory never answers: TIMEOUT wait cycles then HALT with err set.
  task automatic timeout_phase(input logic [2:0] st);
    for (int i = 0; i < 15; i++) begin
      mem_rdy = 1'b0; instr = 8'($urandom); run = 1'($urandom);
      #1 chk("to_wait", obs, pk(1, 0, 0, 3, 0, 0, exp_err, st));
      @(negedge clk);
    end
    exp_err = 1'b1;
    run = 1'b0;
    #1 chk("to_halt", obs, pk(0, 0, 0, 3, 0, 1, 1, 0));
  endtask

  // One full instruction; zf/nf drive the flags in EXEC, run is pulsed there to show it is ignored.
  task automatic do_instr(input logic [2:0] op, input int waits, input int twaits,
                          input logic zf, input logic nf);
    logic [1:0] e_pcc, e_alu;
    logic       e_ald;
    mem_phase(3'd1, {op, 5'($urandom)}, waits);
    mem_rdy = 1'($urandom); instr = 8'($urandom);
    #1 chk("decode", obs, pk(0, 0, 0, 3, 0, 0, exp_err, 2));
    @(negedge clk);
    if (op == 3'b110) begin
      mem_phase(3'd4, 8'($urandom), twaits);
    end else if (op == 3'b111) begin
      halt_run($urandom_range(0, 3));
    end else begin
      e_ald = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
      e_alu = (op == 3'd1) ? 2'd0 : (op == 3'd2) ? 2'd1 : (op == 3'd3) ? 2'd2 : 2'd3;
      e_pcc = ((op == 3'd4 && zf) || (op == 3'd5 && nf)) ? 2'd3 : 2'd0;
      acc_zero = zf; acc_neg = nf; run = 1'b1; mem_rdy = 1'($urandom);
      #1 chk("exec", obs, pk(0, 0, e_pcc, e_alu, e_ald, 0, exp_err, 3));
      @(negedge clk);
      run = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; run = 1'b0; mem_rdy = 1'b0; acc_zero = 1'b0; acc_neg = 1'b0; instr = 8'h00;
    exp_err = 1'b0;
    #12 chk("reset", obs, pk(0, 0, 0, 3, 0, 1, 0, 0));
    @(negedge clk);
    clr = 1'b1;
    halt_run(2);

    // ADD with zero-wait memory
    do_instr(3'b001, 0, 0, 1'b0, 1'b0);
    // SKZ taken / not taken, SKN taken / not taken
    do_instr(3'b100, 0, 0, 1'b1, 1'b0);
    do_instr(3'b100, 0, 0, 1'b0, 1'b1);
    do_instr(3'b101, 1, 0, 1'b0, 1'b1);
    do_instr(3'b101, 0, 0, 1'b1, 1'b0);
    // JMP with target on a 2-wait-cycle mem_rdy
    do_instr(3'b110, 0, 2, 1'b0, 1'b0);
    // mem_rdy on wait cycle 15 is still accepted
    do_instr(3'b010, 14, 0, 1'b0, 1'b0);
    do_instr(3'b110, 0, 14, 1'b0, 1'b0);
    // FETCH timeout, then run clears err
    timeout_phase(3'd1);
    @(negedge clk);
    halt_run(1);
    // OPFETCH timeout
    mem_phase(3'd1, 8'hC0, 0);
    #1 chk("decode_jmp", obs, pk(0, 0, 0, 3, 0, 0, exp_err, 2));
    @(negedge clk);
    timeout_phase(3'd4);
    @(negedge clk);
    // clr while in HALT with err set clears the fault
    #2 clr = 1'b0; exp_err = 1'b0;
    #1 chk("clr_err", obs, pk(0, 0, 0, 3, 0, 1, 0, 0));
    @(negedge clk);
    clr = 1'b1;
    halt_run(1);
    // AND, NOP, HLT (run pulsed in the preceding EXEC is ignored)
    do_instr(3'b011, 0, 0, 1'b0, 1'b0);
    do_instr(3'b000, 3, 0, 1'b1, 1'b1);
    do_instr(3'b111, 0, 0, 1'b0, 1'b0);
    // Async clr mid-OPFETCH
    mem_phase(3'd1, 8'hC0, 0);
    #1 chk("decode_jmp2", obs, pk(0, 0, 0, 3, 0, 0, exp_err, 2));
    @(negedge clk);
    mem_rdy = 1'b0;
    #1 chk("opf_pre_clr", obs, pk(1, 0, 0, 3, 0, 0, exp_err, 4));
    #2 clr = 1'b0;
    #1 chk("clr_async", obs, pk(0, 0, 0, 3, 0, 1, 0, 0));
    @(negedge clk);
    clr = 1'b1;
    halt_run(1);

    // Random instruction stream with occasional memory timeouts
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        timeout_phase(3'd1);
        @(negedge clk);
        halt_run($urandom_range(0, 2));
      end else begin
        do_instr(3'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : 0,
                 $urandom_range(0, 4), 1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
